// File: rtl/decode_pipe_reg.sv
// decode_pipe_reg
//
// Decode -> execute pipeline register carrying a bundle of LANES instruction
// slots. A main register (M) drives the outputs. A skid register (S) absorbs
// one more bundle when execute stalls, so in_ready is registered state rather
// than a combinational function of out_ready. The stage also inserts hazard
// bubbles, flushes on a branch mispredict, and keeps a saturating count of
// the bubbles it has emitted.
//
// All state changes on the falling clock edge.
//
// Ports
//   clk         stage clock; state updates on negedge
//   rst         asynchronous, active-low reset
//   in_valid    per-lane valid of the upstream bundle
//   in_data     upstream payload; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready    bundle accepted when high (registered; gated by hazard/flush)
//   hazard      data hazard: stall upstream, emit bubble downstream
//   flush       branch mispredict: discard held and incoming bundles
//   out_valid   per-lane valid toward execute
//   out_data    execute payload; invalid lanes are all-zero
//   out_ready   execute accepts the bundle
//   bubble_cnt  saturating count of hazard bubbles emitted
//   occupancy   bundles held: 0, 1 or 2
module decode_pipe_reg #(
    parameter int DATA_WIDTH = 128,
    parameter int LANES      = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES-1:0]            in_valid,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        in_ready,
    input  logic                        hazard,
    input  logic                        flush,
    output logic [LANES-1:0]            out_valid,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    input  logic                        out_ready,
    output logic [CNT_WIDTH-1:0]        bubble_cnt,
    output logic [1:0]                  occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [LANES-1:0]            m_valid_q, m_valid_d;
    logic [LANES*DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [LANES-1:0]            s_valid_q, s_valid_d;
    logic [LANES*DATA_WIDTH-1:0] s_data_q, s_data_d;
    logic [CNT_WIDTH-1:0]        bubble_cnt_q, bubble_cnt_d;
    logic                        rdy_q, rdy_d;

    logic [LANES*DATA_WIDTH-1:0] in_masked;
    logic                        acc;
    logic                        dq;
    logic                        bubble;

    // Invalid lanes are stored with a zero payload so execute sees NOPs.
    always_comb begin
        in_masked = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (in_valid[i]) begin
                in_masked[i*DATA_WIDTH +: DATA_WIDTH] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // rdy_q mirrors "S empty"; hazard and flush only gate it combinationally.
    assign in_ready = rdy_q & ~hazard & ~flush;
    assign acc      = (|in_valid) & in_ready;
    assign dq       = (|m_valid_q) & out_ready;

    always_comb begin
        state_d      = state_q;
        m_valid_d    = m_valid_q;
        m_data_d     = m_data_q;
        s_valid_d    = s_valid_q;
        s_data_d     = s_data_q;
        bubble_cnt_d = bubble_cnt_q;
        bubble       = 1'b0;

        if (flush) begin
            state_d   = EMPTY;
            m_valid_d = '0;
            m_data_d  = '0;
            s_valid_d = '0;
            s_data_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        m_valid_d = in_valid;
                        m_data_d  = in_masked;
                        state_d   = ONE;
                    end else if (hazard) begin
                        // M is already cleared, which is exactly the bubble.
                        bubble = 1'b1;
                    end
                end
                ONE: begin
                    if (dq && acc) begin
                        m_valid_d = in_valid;
                        m_data_d  = in_masked;
                    end else if (dq) begin
                        m_valid_d = '0;
                        m_data_d  = '0;
                        state_d   = EMPTY;
                        bubble    = hazard;
                    end else if (acc) begin
                        s_valid_d = in_valid;
                        s_data_d  = in_masked;
                        state_d   = FULL;
                    end
                end
                FULL: begin
                    if (dq) begin
                        m_valid_d = s_valid_q;
                        m_data_d  = s_data_q;
                        s_valid_d = '0;
                        s_data_d  = '0;
                        state_d   = ONE;
                    end
                end
                default: begin
                    state_d   = EMPTY;
                    m_valid_d = '0;
                    m_data_d  = '0;
                    s_valid_d = '0;
                    s_data_d  = '0;
                end
            endcase
        end

        if (bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
        end

        rdy_d = (state_d != FULL);
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            m_valid_q    <= '0;
            m_data_q     <= '0;
            s_valid_q    <= '0;
            s_data_q     <= '0;
            bubble_cnt_q <= '0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            s_valid_q    <= s_valid_d;
            s_data_q     <= s_data_d;
            bubble_cnt_q <= bubble_cnt_d;
            rdy_q        <= rdy_d;
        end
    end

    assign out_valid  = m_valid_q;
    assign out_data   = m_data_q;
    assign bubble_cnt = bubble_cnt_q;
    assign occupancy  = state_q;

endmodule
